reorder_buffer: RTL and testbench

In-order commit buffer that allocates reservation tags at dispatch, collects out-of-order completion results, and retires them in program order into the renaming register file. It drives the register file's `rsv`/`rob_id` reservation port and its `we`/`wrQueAddr`/`wrAddr`/`wrData` commit port. On commit of a mispredicted branch it asserts `branch_miss`, which flushes both this buffer and the register file's tags. Depth is 2**RSV_ID_W entries; widths come from `fcpu_pkg`.

---
 rtl/reorder_buffer.sv | 191 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order commit buffer: tags allocated at dispatch, out-of-order completion, in-order retire.
// Optional FCPU_ROB_CMPL_FWD_EN: a completion hitting the waiting head commits at the same edge.
package fcpu_pkg;
  parameter int unsigned RSV_ID_W   = 2;
  parameter int unsigned REG_ADDR_W = 5;
  parameter int unsigned DATA_W     = 32;
endpackage

module reorder_buffer
  import fcpu_pkg::*;
#(
  parameter int unsigned N_CMPL_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             alloc_valid,
  input  logic                             alloc_wen,
  input  logic [REG_ADDR_W-1:0]            alloc_dst,
  output logic                             alloc_ready,
  output logic                             rsv,
  output logic [RSV_ID_W-1:0]              rob_id,
  input  logic [N_CMPL_PORTS-1:0]          cmpl_valid,
  input  logic [N_CMPL_PORTS*RSV_ID_W-1:0] cmpl_id,
  input  logic [N_CMPL_PORTS*DATA_W-1:0]   cmpl_data,
  input  logic [N_CMPL_PORTS-1:0]          cmpl_miss,
  output logic                             we,
  output logic [RSV_ID_W-1:0]              wrQueAddr,
  output logic [REG_ADDR_W-1:0]            wrAddr,
  output logic [DATA_W-1:0]                wrData,
  output logic                             branch_miss,
  output logic [RSV_ID_W:0]                count
);

  localparam int unsigned Depth = 2 ** RSV_ID_W;
  localparam int unsigned CntW  = RSV_ID_W + 1;

  logic [Depth-1:0]      valid_q, valid_d, done_q, done_d, miss_q, miss_d, wen_q, wen_d;
  logic [REG_ADDR_W-1:0] dst_q [Depth];
  logic [REG_ADDR_W-1:0] dst_d [Depth];
  logic [DATA_W-1:0]     data_q [Depth];
  logic [DATA_W-1:0]     data_d [Depth];
  logic [RSV_ID_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;

  logic                  we_q, we_d, branch_miss_q, branch_miss_d;
  logic [RSV_ID_W-1:0]   wr_que_addr_q, wr_que_addr_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  logic [Depth-1:0]      hit, hit_miss;
  logic [DATA_W-1:0]     hit_data [Depth];
  logic                  commit, commit_miss, flush;
  logic [DATA_W-1:0]     commit_data;

  assign alloc_ready = (count_q != CntW'(Depth)) & ~branch_miss_q;
  assign rsv         = alloc_valid & alloc_ready;
  assign rob_id      = tail_q;
  assign we          = we_q;
  assign wrQueAddr   = wr_que_addr_q;
  assign wrAddr      = wr_addr_q;
  assign wrData      = wr_data_q;
  assign branch_miss = branch_miss_q;
  assign count       = count_q;

  // Per-entry completion select; scanning high to low lets the lowest port win.
  always_comb begin
    for (int e = 0; e < Depth; e++) begin
      hit[e]      = 1'b0;
      hit_miss[e] = 1'b0;
      hit_data[e] = '0;
      for (int p = N_CMPL_PORTS - 1; p >= 0; p--) begin
        if (cmpl_valid[p] && (cmpl_id[p*RSV_ID_W +: RSV_ID_W] == RSV_ID_W'(e))) begin
          hit[e]      = 1'b1;
          hit_miss[e] = cmpl_miss[p];
          hit_data[e] = cmpl_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    commit      = valid_q[head_q] & done_q[head_q];
    commit_data = data_q[head_q];
    commit_miss = miss_q[head_q];
`ifdef FCPU_ROB_CMPL_FWD_EN
    if (valid_q[head_q] && !done_q[head_q] && hit[head_q]) begin
      commit      = 1'b1;
      commit_data = hit_data[head_q];
      commit_miss = hit_miss[head_q];
    end
`endif
    flush = commit & commit_miss;
  end

  always_comb begin
    valid_d       = valid_q;
    done_d        = done_q;
    miss_d        = miss_q;
    wen_d         = wen_q;
    dst_d         = dst_q;
    data_d        = data_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    we_d          = 1'b0;
    wr_que_addr_d = wr_que_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    branch_miss_d = flush;

    for (int e = 0; e < Depth; e++) begin
      if (hit[e] && valid_q[e] && !done_q[e]) begin
        done_d[e] = 1'b1;
        miss_d[e] = hit_miss[e];
        data_d[e] = hit_data[e];
      end
    end

    if (rsv) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      miss_d[tail_q]  = 1'b0;
      wen_d[tail_q]   = alloc_wen;
      dst_d[tail_q]   = alloc_dst;
      tail_d          = tail_q + RSV_ID_W'(1);
    end

    if (commit) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + RSV_ID_W'(1);
      we_d            = wen_q[head_q];
      wr_que_addr_d   = head_q;
      wr_addr_d       = dst_q[head_q];
      wr_data_d       = commit_data;
    end

    unique case ({rsv, commit})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Mispredict discards everything younger, including this cycle's alloc/completions.
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      miss_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q       <= '0;
      done_q        <= '0;
      miss_q        <= '0;
      wen_q         <= '0;
      for (int e = 0; e < Depth; e++) begin
        dst_q[e]  <= '0;
        data_q[e] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      we_q          <= 1'b0;
      branch_miss_q <= 1'b0;
      wr_que_addr_q <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      valid_q       <= valid_d;
      done_q        <= done_d;
      miss_q        <= miss_d;
      wen_q         <= wen_d;
      dst_q         <= dst_d;
      data_q        <= data_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      we_q          <= we_d;
      branch_miss_q <= branch_miss_d;
      wr_que_addr_q <= wr_que_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed stimulus pushes expected commits, a monitor pops.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_wen = 1'b0;
  logic [4:0]  alloc_dst = '0;
  logic        alloc_ready, rsv;
  logic [1:0]  rob_id;
  logic [1:0]  cmpl_valid = '0;
  logic [3:0]  cmpl_id = '0;
  logic [63:0] cmpl_data = '0;
  logic [1:0]  cmpl_miss = '0;
  logic        we, branch_miss;
  logic [1:0]  wrQueAddr;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [2:0]  count;

  reorder_buffer #(.N_CMPL_PORTS(2)) dut (
    .clk(clk), .nrst(nrst),
    .alloc_valid(alloc_valid), .alloc_wen(alloc_wen), .alloc_dst(alloc_dst),
    .alloc_ready(alloc_ready), .rsv(rsv), .rob_id(rob_id),
    .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_data(cmpl_data), .cmpl_miss(cmpl_miss),
    .we(we), .wrQueAddr(wrQueAddr), .wrAddr(wrAddr), .wrData(wrData),
    .branch_miss(branch_miss), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  que;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        bm;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       m_exp;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_tail = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic w, input logic [1:0] q, input logic [4:0] a,
                      input logic [31:0] d, input logic b);
    exp_t e;
    e.we = w; e.que = q; e.addr = a; e.data = d; e.bm = b;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_alloc(input logic w, input logic [4:0] dst);
    alloc_valid = 1'b1; alloc_wen = w; alloc_dst = dst;
    #1;
    chk("alloc_ready", alloc_ready, 1'b1);
    chk("rob_id", rob_id, exp_tail);
    step();
    alloc_valid = 1'b0;
    exp_tail = exp_tail + 2'd1;
  endtask

  task automatic complete(input logic v0, input logic [1:0] id0, input logic [31:0] d0,
                          input logic m0, input logic v1, input logic [1:0] id1,
                          input logic [31:0] d1, input logic m1);
    cmpl_valid = {v1, v0}; cmpl_id = {id1, id0}; cmpl_data = {d1, d0}; cmpl_miss = {m1, m0};
    step();
    cmpl_valid = '0; cmpl_miss = '0;
  endtask

  // Monitor: every visible commit must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst && (we || branch_miss)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_commit: got we=%0b que=%0d addr=%0d bm=%0b, expected none",
                 we, wrQueAddr, wrAddr, branch_miss);
      end else begin
        m_exp = exp_q.pop_front();
        chk("commit_we", we, m_exp.we);
        chk("commit_que", wrQueAddr, m_exp.que);
        chk("commit_addr", wrAddr, m_exp.addr);
        chk("commit_data", wrData, m_exp.data);
        chk("commit_bm", branch_miss, m_exp.bm);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst_we", we, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_bm", branch_miss, 1'b0);
    #10;
    nrst = 1'b1;
    chk("rst_ready", alloc_ready, 1'b1);
    chk("rst_rob_id", rob_id, 2'd0);

    // In-order commit from out-of-order completion
    do_alloc(1'b1, 5'd5);
    do_alloc(1'b1, 5'd6);
    do_alloc(1'b1, 5'd7);
    chk("t1_count", count, 3'd3);
    push(1'b1, 2'd0, 5'd5, 32'h20, 1'b0);
    push(1'b1, 2'd1, 5'd6, 32'h21, 1'b0);
    push(1'b1, 2'd2, 5'd7, 32'h22, 1'b0);
    complete(1'b1, 2'd2, 32'h22, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    complete(1'b1, 2'd0, 32'h20, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    complete(1'b1, 2'd1, 32'h21, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    idle(6);
    chk("t1_drain", count, 3'd0);

    // Fill, then alloc while full in the same cycle as a commit
    do_alloc(1'b1, 5'd8);
    do_alloc(1'b1, 5'd9);
    do_alloc(1'b1, 5'd10);
    do_alloc(1'b1, 5'd11);
    chk("t2_full_ready", alloc_ready, 1'b0);
    chk("t2_full_count", count, 3'd4);
    push(1'b1, 2'd3, 5'd8, 32'h30, 1'b0);
    complete(1'b1, 2'd3, 32'h30, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_dst = 5'd15;
    #1;
    chk("t2_rsv_blocked", rsv, 1'b0);
    step();
    alloc_valid = 1'b0;
    chk("t2_count_dec", count, 3'd3);
    do_alloc(1'b1, 5'd12);
    chk("t2_tail_wrap", rob_id, 2'd0);
    push(1'b1, 2'd0, 5'd9, 32'h40, 1'b0);
    push(1'b1, 2'd1, 5'd10, 32'h41, 1'b0);
    push(1'b1, 2'd2, 5'd11, 32'h42, 1'b0);
    push(1'b1, 2'd3, 5'd12, 32'hA, 1'b0);
    complete(1'b1, 2'd0, 32'h40, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    complete(1'b1, 2'd1, 32'h41, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    complete(1'b1, 2'd2, 32'h42, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    complete(1'b1, 2'd3, 32'hA, 1'b0, 1'b1, 2'd3, 32'hB, 1'b0);
    idle(6);
    chk("t2_drain", count, 3'd0);

    // Entry without a destination write retires silently
    do_alloc(1'b0, 5'd13);
    do_alloc(1'b1, 5'd14);
    push(1'b1, 2'd1, 5'd14, 32'h71, 1'b0);
    complete(1'b1, 2'd0, 32'h70, 1'b0, 1'b1, 2'd1, 32'h71, 1'b0);
    idle(5);
    chk("t3_count", count, 3'd0);
    chk("t3_que_hold", wrQueAddr, 2'd1);

    // Mispredicted branch flushes younger entries
    do_alloc(1'b1, 5'd16);
    do_alloc(1'b1, 5'd17);
    do_alloc(1'b1, 5'd18);
    do_alloc(1'b1, 5'd19);
    complete(1'b1, 2'd0, 32'h99, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    push(1'b1, 2'd2, 5'd16, 32'h50, 1'b0);
    push(1'b1, 2'd3, 5'd17, 32'h51, 1'b1);
    complete(1'b1, 2'd2, 32'h50, 1'b0, 1'b1, 2'd3, 32'h51, 1'b1);
    step();
    step();
    exp_tail = 2'd0;
    chk("t4_bm_high", branch_miss, 1'b1);
    chk("t4_ready_low", alloc_ready, 1'b0);
    chk("t4_count", count, 3'd0);
    step();
    chk("t4_bm_pulse", branch_miss, 1'b0);
    chk("t4_rob_id", rob_id, 2'd0);
    chk("t4_ready", alloc_ready, 1'b1);
    idle(5);

    // Asynchronous reset with work in flight
    do_alloc(1'b1, 5'd20);
    do_alloc(1'b1, 5'd21);
    do_alloc(1'b1, 5'd22);
    do_alloc(1'b1, 5'd23);
    push(1'b1, 2'd0, 5'd20, 32'h60, 1'b0);
    complete(1'b1, 2'd0, 32'h60, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    complete(1'b1, 2'd1, 32'h61, 1'b0, 1'b1, 2'd2, 32'h62, 1'b0);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("t5_we", we, 1'b0);
    chk("t5_que", wrQueAddr, 2'd0);
    chk("t5_addr", wrAddr, 5'd0);
    chk("t5_data", wrData, 32'd0);
    chk("t5_count", count, 3'd0);
    chk("t5_ready", alloc_ready, 1'b1);
    chk("t5_rob_id", rob_id, 2'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    idle(6);
    chk("t5_count_after", count, 3'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
